// File: rtl/uart_rx_if.sv
// uart_rx_if: parallel read port of the UART receiver.
//   rd        - read strobe from the bus side; consumes the byte in dout
//   dout      - last received byte
//   valid     - dout holds an unread byte
//   frame_err - last frame ended with a low stop bit
//   overrun   - an unread byte was overwritten by a newer one
//   busy      - receiver is somewhere inside a frame
// master = bus side, slave = receiver.
interface uart_rx_if;
    logic       rd;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (output rd, input dout, valid, frame_err, overrun, busy);
    modport slave  (input rd, output dout, valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and mid-bit sampling.
//   clk   - system clock (sys_clk Hz)
//   reset - synchronous, active-high
//   rx    - serial input, asynchronous to clk, idle high
//   bus   - read port (rd in; dout/valid/frame_err/overrun/busy out)
// Parameters: sys_clk (Hz), rate (bps); sys_clk/(rate*16) must be >= 1.
module uart_rx #(
    parameter int sys_clk = 27000000,
    parameter int rate    = 19200
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rx,
    uart_rx_if.slave bus
);
    localparam int          OS_DIV   = sys_clk / (rate * 16) - 1;
    localparam logic [31:0] OS_DIV_W = 32'(OS_DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state;
    logic        s1, s2;
    logic [31:0] os_cnt;
    logic        tick;
    logic [3:0]  scnt;
    logic [2:0]  bcnt;
    logic [7:0]  shreg;
    logic [7:0]  dout_r;
    logic        valid_r, ferr_r, ovr_r;

    assign tick = (os_cnt == OS_DIV_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            s1      <= 1'b1;
            s2      <= 1'b1;
            os_cnt  <= '0;
            scnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            dout_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            s1 <= rx;
            s2 <= s1;
            os_cnt <= tick ? '0 : os_cnt + 32'd1;

            if (bus.rd && valid_r) begin
                valid_r <= 1'b0;
                ovr_r   <= 1'b0;
            end

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!s2) begin
                            state <= START;
                            scnt  <= '0;
                        end
                    end
                    START: begin
                        scnt <= scnt + 4'd1;
                        // scnt reaches 7 on this tick: middle of the start bit,
                        // so later samples land at 7 + 16(k+1) ticks after detection.
                        if (scnt == 4'd6) begin
                            if (!s2) begin
                                state <= DATA;
                                scnt  <= '0;
                                bcnt  <= '0;
                            end else begin
                                state <= IDLE;   // glitch, nothing reported
                            end
                        end
                    end
                    DATA: begin
                        scnt <= scnt + 4'd1;     // wraps to 0 on the sample tick
                        if (scnt == 4'd15) begin
                            shreg <= {s2, shreg[7:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7) state <= STOP;
                        end
                    end
                    STOP: begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            if (s2) begin
                                // Delivery overrides the read-clear above: a read in
                                // the same cycle consumes the old byte, so no overrun.
                                dout_r  <= shreg;
                                valid_r <= 1'b1;
                                ferr_r  <= 1'b0;
                                ovr_r   <= valid_r && !bus.rd;
                                state   <= IDLE;
                            end else begin
                                ferr_r <= 1'b1;
                                state  <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (s2) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout      = dout_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = ferr_r;
    assign bus.overrun   = ovr_r;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int SYS_CLK = 3200000;
    localparam int RATE    = 100000;
    localparam int BIT_CLK = 32;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    int   pass_cnt = 0;
    int   total    = 0;

    uart_rx_if bus ();

    uart_rx #(.sys_clk(SYS_CLK), .rate(RATE)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: what the read port should show, from frames sent and reads made.
    logic [7:0] m_dout;
    logic       m_valid, m_ferr, m_ovr;

    function automatic void model_reset();
        m_dout = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            m_ovr   = m_valid;
            m_dout  = b;
            m_valid = 1'b1;
            m_ferr  = 1'b0;
        end else begin
            m_ferr = 1'b1;
        end
    endfunction

    function automatic void model_rd();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (BIT_CLK - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; bus.rd = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if ({bus.dout, bus.valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000)
            $display("FAIL reset_state: got dout=%h v=%b fe=%b ov=%b busy=%b, want all 0",
                     bus.dout, bus.valid, bus.frame_err, bus.overrun, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        total++;
        if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== {m_dout, m_valid, m_ferr, m_ovr})
            $display("FAIL a5_rx: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=%b ov=%b",
                     bus.dout, bus.valid, bus.frame_err, bus.overrun, m_dout, m_valid, m_ferr, m_ovr);
        else pass_cnt++;
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        model_rd();
        total++;
        if (bus.valid !== 1'b0)
            $display("FAIL a5_rd_clear: valid=%b want 0 one clock after rd", bus.valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1);
        model_frame(8'h00, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                total++;
                if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== {m_dout, m_valid, m_ferr, m_ovr})
                    $display("FAIL b2b_first: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=0 ov=0",
                             bus.dout, bus.valid, bus.frame_err, bus.overrun, m_dout, m_valid);
                else pass_cnt++;
                pulse_rd();
                model_rd();
            end
        join
        model_frame(8'hFF, 1'b1);
        total++;
        if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== {m_dout, m_valid, m_ferr, m_ovr})
            $display("FAIL b2b_second: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=%b ov=%b",
                     bus.dout, bus.valid, bus.frame_err, bus.overrun, m_dout, m_valid, m_ferr, m_ovr);
        else pass_cnt++;
        pulse_rd();
        model_rd();
    endtask

    task automatic test_overrun();
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        total++;
        if ({bus.dout, bus.valid, bus.overrun} !== {m_dout, m_valid, m_ovr} || m_ovr !== 1'b1)
            $display("FAIL overrun_set: got dout=%h v=%b ov=%b want dout=%h v=1 ov=1",
                     bus.dout, bus.valid, bus.overrun, m_dout);
        else pass_cnt++;
        pulse_rd();
        model_rd();
        total++;
        if ({bus.valid, bus.overrun} !== {m_valid, m_ovr})
            $display("FAIL overrun_clear: got v=%b ov=%b want v=0 ov=0", bus.valid, bus.overrun);
        else pass_cnt++;
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);            // rx left low after the stop bit
        model_frame(8'h55, 1'b0);
        repeat (19 * BIT_CLK) @(negedge clk);
        total++;
        if ({bus.frame_err, bus.valid, bus.busy} !== {m_ferr, m_valid, 1'b1})
            $display("FAIL ferr_hold: got fe=%b v=%b busy=%b want fe=1 v=0 busy=1",
                     bus.frame_err, bus.valid, bus.busy);
        else pass_cnt++;
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        total++;
        if ({bus.busy, bus.frame_err} !== {1'b0, m_ferr})
            $display("FAIL ferr_release: got busy=%b fe=%b want busy=0 fe=1", bus.busy, bus.frame_err);
        else pass_cnt++;
        send_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1);
        total++;
        if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== {m_dout, m_valid, m_ferr, m_ovr})
            $display("FAIL ferr_recover: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=%b ov=%b",
                     bus.dout, bus.valid, bus.frame_err, bus.overrun, m_dout, m_valid, m_ferr, m_ovr);
        else pass_cnt++;
        pulse_rd();
        model_rd();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1)
            $display("FAIL glitch_seen: busy=%b want 1 while checking start bit", bus.busy);
        else pass_cnt++;
        repeat (2 * BIT_CLK) @(negedge clk);
        total++;
        if ({bus.busy, bus.valid, bus.frame_err} !== {1'b0, m_valid, m_ferr})
            $display("FAIL glitch_idle: got busy=%b v=%b fe=%b want busy=0 v=%b fe=%b",
                     bus.busy, bus.valid, bus.frame_err, m_valid, m_ferr);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        send_frame(8'h5A, 1'b1);            // left unread; reset must drop it
        model_frame(8'h5A, 1'b1);
        b = 8'hE7;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLK - 1) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (BIT_CLK / 2) @(negedge clk);
        end
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if ({bus.dout, bus.valid, bus.frame_err, bus.overrun, bus.busy} !== {m_dout, m_valid, m_ferr, m_ovr, 1'b0})
            $display("FAIL midreset_state: got dout=%h v=%b fe=%b ov=%b busy=%b want all 0",
                     bus.dout, bus.valid, bus.frame_err, bus.overrun, bus.busy);
        else pass_cnt++;
        repeat (2 * BIT_CLK) @(negedge clk);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        total++;
        if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== {m_dout, m_valid, m_ferr, m_ovr})
            $display("FAIL midreset_next: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=%b ov=%b",
                     bus.dout, bus.valid, bus.frame_err, bus.overrun, m_dout, m_valid, m_ferr, m_ovr);
        else pass_cnt++;
        pulse_rd();
        model_rd();
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
            total++;
            if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== {m_dout, m_valid, m_ferr, m_ovr})
                $display("FAIL rand_rx[%0d]: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=%b ov=%b",
                         n, bus.dout, bus.valid, bus.frame_err, bus.overrun, m_dout, m_valid, m_ferr, m_ovr);
            else pass_cnt++;
            if ($urandom_range(0, 2) != 0) begin
                pulse_rd();
                model_rd();
                total++;
                if ({bus.valid, bus.overrun} !== {m_valid, m_ovr})
                    $display("FAIL rand_rd[%0d]: got v=%b ov=%b want v=%b ov=%b",
                             n, bus.valid, bus.overrun, m_valid, m_ovr);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
